// File: rtl/ltl_symbol_streamer.sv
// ltl_symbol_streamer
// Transmit end of the runtime-monitor symbol interface. Buffers per-cycle
// proposition vectors in a small FIFO and drives the shared symbol / run /
// reset inputs of a cluster of monitor automata, owning the session sequence
// (IDLE -> MRESET -> STREAM). Monitor reset is released on the same edge that
// presents the first symbol, so every automaton start state sees it.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   sess_start/sess_stop  session control pulses (start wins when both)
//   evt_valid/evt_props   proposition vector input, evt_ready = can accept
//   sym_out/sym_run       symbol and advance strobe to the monitors
//   mon_reset             reset to the monitors
//   busy                  session active (MRESET or STREAM)
//   level                 FIFO occupancy
//   drop_count            saturating count of events refused during a session
module ltl_symbol_streamer #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned RST_CYCLES = 2,
    parameter int unsigned DEDUP      = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sess_start,
    input  logic                     sess_stop,
    input  logic                     evt_valid,
    input  logic [7:0]               evt_props,
    output logic                     evt_ready,
    output logic [7:0]               sym_out,
    output logic                     sym_run,
    output logic                     mon_reset,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level,
    output logic [15:0]              drop_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH) + 1;
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MRESET = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [7:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [LW-1:0]   r_level;
    logic [CW-1:0]   r_cnt;
    logic [7:0]      r_sym;
    logic            r_run;
    logic            r_mrst;
    logic [7:0]      r_last;
    logic            r_lastv;
    logic [15:0]     r_drop;
    logic            r_evt_ready;
    logic            r_busy;

    logic [AW-1:0]   w_wr_ptr_nxt;
    logic [AW-1:0]   w_rd_ptr_nxt;
    logic [LW-1:0]   w_level_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [7:0]      w_sym_nxt;
    logic            w_run_nxt;
    logic            w_mrst_nxt;
    logic [7:0]      w_last_nxt;
    logic            w_lastv_nxt;
    logic [15:0]     w_drop_nxt;
    logic            w_ready;
    logic            w_push;
    logic            w_pop;
    logic            w_flush;
    logic            w_cnt_done;
    logic            w_is_dup;
    logic [7:0]      w_head;

    // Readiness from current state and occupancy; a same-cycle pop does not help
    assign w_ready    = (r_state != ST_IDLE) && (r_level < LW'(DEPTH));
    assign w_head     = r_mem[r_rd_ptr];
    // r_cnt counts MRESET cycles already completed; the current cycle completes
    // the reset window once RST_CYCLES-1 of them are behind us
    assign w_cnt_done = (r_cnt >= CW'(RST_CYCLES - 1));
    assign w_is_dup   = (DEDUP != 0) && r_lastv && (w_head == r_last);

    // Next-state and datapath decode
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_sym_nxt    = r_sym;
        w_run_nxt    = 1'b0;
        w_mrst_nxt   = r_mrst;
        w_last_nxt   = r_last;
        w_lastv_nxt  = r_lastv;
        w_drop_nxt   = r_drop;
        w_push       = evt_valid && w_ready;
        w_pop        = 1'b0;
        w_flush      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_mrst_nxt = 1'b1;
            end
            ST_MRESET: begin
                w_mrst_nxt = 1'b1;
                if (w_cnt_done && (r_level != '0)) begin
                    w_pop       = 1'b1;
                    w_sym_nxt   = w_head;
                    w_run_nxt   = 1'b1;
                    w_mrst_nxt  = 1'b0;
                    w_last_nxt  = w_head;
                    w_lastv_nxt = 1'b1;
                    w_state_nxt = ST_STREAM;
                end else if (r_cnt < CW'(RST_CYCLES)) begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            ST_STREAM: begin
                w_mrst_nxt = 1'b0;
                if (r_level != '0) begin
                    w_pop = 1'b1;
                    if (!w_is_dup) begin
                        w_sym_nxt   = w_head;
                        w_run_nxt   = 1'b1;
                        w_last_nxt  = w_head;
                        w_lastv_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_mrst_nxt  = 1'b1;
            end
        endcase

        // Events refused while a session is running are counted
        if ((r_state != ST_IDLE) && evt_valid && !w_ready && (r_drop != 16'hFFFF)) begin
            w_drop_nxt = r_drop + 16'd1;
        end

        // Session control overrides everything else; start wins over stop
        if (sess_start) begin
            w_flush     = 1'b1;
            w_push      = 1'b0;
            w_pop       = 1'b0;
            w_state_nxt = ST_MRESET;
            w_cnt_nxt   = '0;
            w_mrst_nxt  = 1'b1;
            w_run_nxt   = 1'b0;
            w_sym_nxt   = r_sym;
            w_last_nxt  = r_last;
            w_lastv_nxt = 1'b0;
            w_drop_nxt  = '0;
        end else if (sess_stop && (r_state != ST_IDLE)) begin
            w_flush     = 1'b1;
            w_push      = 1'b0;
            w_pop       = 1'b0;
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = r_cnt;
            w_mrst_nxt  = 1'b1;
            w_run_nxt   = 1'b0;
            w_sym_nxt   = r_sym;
            w_last_nxt  = r_last;
            w_lastv_nxt = 1'b0;
            w_drop_nxt  = r_drop;
        end
    end

    // FIFO pointer and occupancy update
    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_level_nxt  = r_level;
        if (w_flush) begin
            w_wr_ptr_nxt = '0;
            w_rd_ptr_nxt = '0;
            w_level_nxt  = '0;
        end else begin
            if (w_push) begin
                w_wr_ptr_nxt = r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                w_rd_ptr_nxt = r_rd_ptr + AW'(1);
            end
            w_level_nxt = r_level + LW'(w_push) - LW'(w_pop);
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_cnt       <= '0;
            r_sym       <= '0;
            r_run       <= 1'b0;
            r_mrst      <= 1'b1;
            r_last      <= '0;
            r_lastv     <= 1'b0;
            r_drop      <= '0;
            r_evt_ready <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_level     <= w_level_nxt;
            r_cnt       <= w_cnt_nxt;
            r_sym       <= w_sym_nxt;
            r_run       <= w_run_nxt;
            r_mrst      <= w_mrst_nxt;
            r_last      <= w_last_nxt;
            r_lastv     <= w_lastv_nxt;
            r_drop      <= w_drop_nxt;
            // Registered forms of functions of the next state and occupancy
            r_evt_ready <= (w_state_nxt != ST_IDLE) && (w_level_nxt < LW'(DEPTH));
            r_busy      <= (w_state_nxt != ST_IDLE);
        end
    end

    // FIFO storage, no reset needed
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= evt_props;
        end
    end

    assign evt_ready  = r_evt_ready;
    assign sym_out    = r_sym;
    assign sym_run    = r_run;
    assign mon_reset  = r_mrst;
    assign busy       = r_busy;
    assign level      = r_level;
    assign drop_count = r_drop;

endmodule

// File: tb/tb_ltl_symbol_streamer.sv
// Testbench for ltl_symbol_streamer: two instances (defaults, and DEPTH=4 /
// RST_CYCLES=6 / DEDUP=1) share one stimulus stream and are compared every
// cycle against a queue-based session model, plus directed checks.
module tb_ltl_symbol_streamer;

    logic       clk = 1'b0;
    logic       reset;
    logic       sess_start;
    logic       sess_stop;
    logic       evt_valid;
    logic [7:0] evt_props;

    logic       d0_ready, d0_run, d0_mrst, d0_busy;
    logic [7:0] d0_sym;
    logic [3:0] d0_level;
    logic [15:0] d0_drop;
    logic       d1_ready, d1_run, d1_mrst, d1_busy;
    logic [7:0] d1_sym;
    logic [2:0] d1_level;
    logic [15:0] d1_drop;

    int errors = 0;
    int checks = 0;

    // Reference model state, index 0 = default instance, 1 = small instance
    int          p_depth [2];
    int          p_rst   [2];
    int          p_dedup [2];
    int          m_st    [2];   // 0 idle, 1 monitor reset, 2 streaming
    logic [7:0]  m_q     [0:1][$];
    int          m_cnt   [2];
    logic [7:0]  m_sym   [2];
    logic        m_run   [2];
    logic        m_mrst  [2];
    logic [7:0]  m_last  [2];
    logic        m_lastv [2];
    int          m_drop  [2];

    always #5 clk = ~clk;

    ltl_symbol_streamer #(.DEPTH(8), .RST_CYCLES(2), .DEDUP(0)) u_d0 (
        .clk(clk), .reset(reset), .sess_start(sess_start), .sess_stop(sess_stop),
        .evt_valid(evt_valid), .evt_props(evt_props), .evt_ready(d0_ready),
        .sym_out(d0_sym), .sym_run(d0_run), .mon_reset(d0_mrst), .busy(d0_busy),
        .level(d0_level), .drop_count(d0_drop)
    );

    ltl_symbol_streamer #(.DEPTH(4), .RST_CYCLES(6), .DEDUP(1)) u_d1 (
        .clk(clk), .reset(reset), .sess_start(sess_start), .sess_stop(sess_stop),
        .evt_valid(evt_valid), .evt_props(evt_props), .evt_ready(d1_ready),
        .sym_out(d1_sym), .sym_run(d1_run), .mon_reset(d1_mrst), .busy(d1_busy),
        .level(d1_level), .drop_count(d1_drop)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            m_st[k] = 0; m_q[k].delete(); m_cnt[k] = 0; m_sym[k] = 8'h00;
            m_run[k] = 1'b0; m_mrst[k] = 1'b1; m_last[k] = 8'h00;
            m_lastv[k] = 1'b0; m_drop[k] = 0;
        end
    endtask

    // One clock edge of the session rules for instance k
    task automatic m_tick(input int k);
        logic       rdy;
        logic [7:0] h;
        rdy = (m_st[k] != 0) && (m_q[k].size() < p_depth[k]);
        if (sess_start) begin
            m_q[k].delete(); m_cnt[k] = 0; m_mrst[k] = 1'b1; m_run[k] = 1'b0;
            m_lastv[k] = 1'b0; m_st[k] = 1; m_drop[k] = 0;
        end else if (sess_stop && m_st[k] != 0) begin
            m_q[k].delete(); m_mrst[k] = 1'b1; m_run[k] = 1'b0;
            m_lastv[k] = 1'b0; m_st[k] = 0;
        end else begin
            if (m_st[k] != 0 && evt_valid && !rdy && m_drop[k] < 65535) m_drop[k]++;
            m_run[k] = 1'b0;
            if (m_st[k] == 1) begin
                // reset window covers this cycle plus the ones already spent
                if (m_cnt[k] + 1 >= p_rst[k] && m_q[k].size() != 0) begin
                    h = m_q[k].pop_front();
                    m_sym[k] = h; m_run[k] = 1'b1; m_mrst[k] = 1'b0;
                    m_last[k] = h; m_lastv[k] = 1'b1; m_st[k] = 2;
                end else if (m_cnt[k] < p_rst[k]) begin
                    m_cnt[k]++;
                end
            end else if (m_st[k] == 2 && m_q[k].size() != 0) begin
                h = m_q[k].pop_front();
                if (!(p_dedup[k] != 0 && m_lastv[k] && h == m_last[k])) begin
                    m_sym[k] = h; m_run[k] = 1'b1; m_last[k] = h; m_lastv[k] = 1'b1;
                end
            end
            if (evt_valid && rdy) m_q[k].push_back(evt_props);
        end
    endtask

    task automatic check_all(input string ph);
        chk({ph, " d0.sym_out"},   32'(d0_sym),   32'(m_sym[0]));
        chk({ph, " d0.sym_run"},   32'(d0_run),   32'(m_run[0]));
        chk({ph, " d0.mon_reset"}, 32'(d0_mrst),  32'(m_mrst[0]));
        chk({ph, " d0.busy"},      32'(d0_busy),  32'(m_st[0] != 0));
        chk({ph, " d0.level"},     32'(d0_level), 32'(m_q[0].size()));
        chk({ph, " d0.evt_ready"}, 32'(d0_ready), 32'(m_st[0] != 0 && m_q[0].size() < p_depth[0]));
        chk({ph, " d0.drop"},      32'(d0_drop),  32'(m_drop[0]));
        chk({ph, " d1.sym_out"},   32'(d1_sym),   32'(m_sym[1]));
        chk({ph, " d1.sym_run"},   32'(d1_run),   32'(m_run[1]));
        chk({ph, " d1.mon_reset"}, 32'(d1_mrst),  32'(m_mrst[1]));
        chk({ph, " d1.busy"},      32'(d1_busy),  32'(m_st[1] != 0));
        chk({ph, " d1.level"},     32'(d1_level), 32'(m_q[1].size()));
        chk({ph, " d1.evt_ready"}, 32'(d1_ready), 32'(m_st[1] != 0 && m_q[1].size() < p_depth[1]));
        chk({ph, " d1.drop"},      32'(d1_drop),  32'(m_drop[1]));
    endtask

    task automatic step(input logic st, input logic sp, input logic v, input logic [7:0] p);
        sess_start = st; sess_stop = sp; evt_valid = v; evt_props = p;
        @(posedge clk);
        m_tick(0);
        m_tick(1);
        #1;
        check_all("cyc");
    endtask

    task automatic do_reset(input string ph);
        sess_start = 1'b0; sess_stop = 1'b0; evt_valid = 1'b0; evt_props = 8'h00;
        reset = 1'b1;
        #2;
        m_reset();
        check_all(ph);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_all(ph);
    endtask

    initial begin
        logic [7:0] got0 [$];
        logic [7:0] got1 [$];
        logic [7:0] exp_v [$];
        int         r;
        logic       rs, rp, rv;
        logic [7:0] rd;

        p_depth[0] = 8; p_rst[0] = 2; p_dedup[0] = 0;
        p_depth[1] = 4; p_rst[1] = 6; p_dedup[1] = 1;

        // Reset values
        do_reset("reset");
        chk("reset mon_reset", 32'(d0_mrst), 32'd1);
        chk("reset sym_out",   32'(d0_sym),  32'd0);

        // Basic latency: start, one push, release with first symbol
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h05);
        chk("lat c2 mon_reset", 32'(d0_mrst), 32'd1);
        chk("lat c2 sym_run",   32'(d0_run),  32'd0);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk("lat c3 mon_reset", 32'(d0_mrst), 32'd0);
        chk("lat c3 sym_run",   32'(d0_run),  32'd1);
        chk("lat c3 sym_out",   32'(d0_sym),  32'h05);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk("lat c4 sym_run",   32'(d0_run),  32'd0);

        // Empty FIFO keeps monitors in reset indefinitely
        step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 1'b0, 8'h00);
            chk("wait mon_reset", 32'(d0_mrst), 32'd1);
        end
        step(1'b0, 1'b0, 1'b1, 8'hA1);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk("late mon_reset", 32'(d0_mrst), 32'd0);
        chk("late sym_run",   32'(d0_run),  32'd1);
        chk("late sym_out",   32'(d0_sym),  32'hA1);

        // Stuttering symbols: instance 1 collapses repeats
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h01);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
        got0.delete(); got1.delete();
        exp_v = '{8'h20, 8'h20, 8'h20, 8'h31, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 1'b0, (i < 5), exp_v[i]);
            if (d0_run) got0.push_back(d0_sym);
            if (d1_run) got1.push_back(d1_sym);
        end
        chk("dedup0 pulses", 32'(got0.size()), 32'd5);
        chk("dedup1 pulses", 32'(got1.size()), 32'd3);
        if (got1.size() == 3) begin
            chk("dedup1 sym0", 32'(got1[0]), 32'h20);
            chk("dedup1 sym1", 32'(got1[1]), 32'h31);
            chk("dedup1 sym2", 32'(got1[2]), 32'h20);
        end

        // Back-to-back stream through the 4-deep instance
        got1.delete();
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, (i < 8), 8'(8'h10 + i));
            chk("stream level<=2", 32'(d1_level <= 3'd2), 32'd1);
            if (i >= 1 && i <= 8) chk("stream run continuous", 32'(d1_run), 32'd1);
            if (d1_run) got1.push_back(d1_sym);
        end
        chk("stream count", 32'(got1.size()), 32'd8);
        for (int i = 0; i < got1.size() && i < 8; i++) chk("stream order", 32'(got1[i]), 32'(8'h10 + i));
        chk("stream drops", 32'(d1_drop), 32'd0);

        // Fill during the long reset window of the 4-deep instance
        step(1'b1, 1'b0, 1'b0, 8'h00);
        got1.delete();
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'(8'h40 + i));
            if (i == 3) begin
                chk("fill ready", 32'(d1_ready), 32'd0);
                chk("fill level", 32'(d1_level), 32'd4);
            end
        end
        chk("fill drops", 32'(d1_drop), 32'd2);
        if (d1_run) got1.push_back(d1_sym);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b0, 8'h00);
            if (d1_run) got1.push_back(d1_sym);
        end
        chk("fill count", 32'(got1.size()), 32'd4);
        for (int i = 0; i < got1.size() && i < 4; i++) chk("fill order", 32'(got1[i]), 32'(8'h40 + i));

        // Stop mid-stream with a backlog; the offered event is discarded
        step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 8'(8'h50 + i));
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk("stop pre level", 32'(d1_level), 32'd3);
        step(1'b0, 1'b1, 1'b1, 8'h77);
        chk("stop mon_reset", 32'(d1_mrst),  32'd1);
        chk("stop level",     32'(d1_level), 32'd0);
        chk("stop ready",     32'(d1_ready), 32'd0);
        chk("stop busy",      32'(d1_busy),  32'd0);

        // Start and stop together: restart wins
        step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 8'(8'h60 + i));
        chk("both pre level", 32'(d1_level), 32'd3);
        chk("both pre drop",  32'(d1_drop),  32'd2);
        step(1'b1, 1'b1, 1'b1, 8'h88);
        chk("both busy",      32'(d1_busy),  32'd1);
        chk("both mon_reset", 32'(d1_mrst),  32'd1);
        chk("both level",     32'(d1_level), 32'd0);
        chk("both drop",      32'(d1_drop),  32'd0);

        // Randomised traffic with occasional session pulses and one async reset
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset("midreset");
            r  = int'($urandom_range(0, 99));
            rs = (r < 2) || (r == 4);
            rp = (r >= 2 && r < 5);
            rv = ($urandom_range(0, 9) < 6);
            rd = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            step(rs, rp, rv, rd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
